// File: rtl/instr_decode_if.sv
// ---------------------------------------------------------------------------
// instr_decode_if
// Bus between the fetch side, the decode/issue stage and the datapath
// control inputs.
//   master : fetch / environment side. Drives in_valid, in_word, hold and
//            observes in_ready plus every issued control field.
//   slave  : the decoder. Drives in_ready and every control output.
// Signals:
//   in_valid, in_ready, in_word : fetch handshake (transfer = valid & ready)
//   hold                        : downstream stall
//   op, form, vec, A-D, Y1, Y2,
//   zero_reg, write, const_a,
//   constant                    : registered datapath controls
//   issued_count, illegal       : status
// ---------------------------------------------------------------------------
interface instr_decode_if #(
    parameter int INSTR_W = 36,
    parameter int CNT_W   = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_word;
    logic               hold;
    logic [2:0]         op;
    logic               form;
    logic [1:0]         vec;
    logic [3:0]         A;
    logic [3:0]         B;
    logic [3:0]         C;
    logic [3:0]         D;
    logic [3:0]         zero_reg;
    logic [3:0]         Y1;
    logic [3:0]         Y2;
    logic [1:0]         write;
    logic               const_a;
    logic [31:0]        constant;
    logic [CNT_W-1:0]   issued_count;
    logic               illegal;

    modport master (
        output in_valid, in_word, hold,
        input  in_ready, op, form, vec, A, B, C, D, zero_reg, Y1, Y2,
               write, const_a, constant, issued_count, illegal
    );

    modport slave (
        input  in_valid, in_word, hold,
        output in_ready, op, form, vec, A, B, C, D, zero_reg, Y1, Y2,
               write, const_a, constant, issued_count, illegal
    );
endinterface

// File: rtl/instr_decode.sv
// ---------------------------------------------------------------------------
// instr_decode
// Decode/issue stage feeding the datapath. Accepts op words (and the
// constant word that follows a const-flagged op word) from fetch, and drives
// every datapath control from registers. Cycles with nothing to issue are
// bubbles (write=00, const_a=0); other fields keep their last values.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : instr_decode_if.slave (handshake, controls, status)
// ---------------------------------------------------------------------------
module instr_decode #(
    parameter int INSTR_W = 36,
    parameter int CNT_W   = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    instr_decode_if.slave  bus
);

    typedef enum logic {S_OP, S_CONST} state_t;

    state_t             state_q;
    logic [34:0]        pendWord_q;
    logic               pendIllegal_q;

    logic [2:0]         op_q;
    logic               form_q;
    logic [1:0]         vec_q;
    logic [3:0]         a_q, b_q, c_q, d_q;
    logic [3:0]         zeroReg_q;
    logic [3:0]         y1_q, y2_q;
    logic [1:0]         write_q;
    logic               constA_q;
    logic [31:0]        constant_q;
    logic [CNT_W-1:0]   issuedCount_q;
    logic               illegal_q;

    logic [INSTR_W-1:0] word;
    logic               wordIllegal;
    logic               wordConst;
    logic [34:0]        issueWord_d;
    logic               issueIllegal_d;
    logic               issueConst_d;
    logic               issueNow_d;

    // The stall is the only thing that ever refuses a word.
    assign bus.in_ready = ~bus.hold;

    // Pick what would issue this cycle: in S_CONST it is the pending op
    // fields (the incoming word is the constant); in S_OP it is the incoming
    // word itself, unless it is a const-flagged word that must wait.
    always_comb begin
        word           = bus.in_word;
        wordIllegal    = |word[26:24];
        wordConst      = word[35];
        issueWord_d    = word[34:0];
        issueIllegal_d = wordIllegal;
        issueConst_d   = 1'b0;
        issueNow_d     = bus.in_valid & ~wordConst;
        if (state_q == S_CONST) begin
            issueWord_d    = pendWord_q;
            issueIllegal_d = pendIllegal_q;
            issueConst_d   = 1'b1;
            issueNow_d     = bus.in_valid;
        end
    end

    // Sequencer and output registers. Hold freezes everything; otherwise
    // each cycle defaults to a bubble and is overwritten when something
    // issues. Illegal words still issue, but with write suppressed and
    // without bumping the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_OP;
            pendWord_q    <= '0;
            pendIllegal_q <= 1'b0;
            op_q          <= '0;
            form_q        <= 1'b0;
            vec_q         <= '0;
            a_q           <= '0;
            b_q           <= '0;
            c_q           <= '0;
            d_q           <= '0;
            zeroReg_q     <= '0;
            y1_q          <= '0;
            y2_q          <= '0;
            write_q       <= '0;
            constA_q      <= 1'b0;
            constant_q    <= '0;
            issuedCount_q <= '0;
            illegal_q     <= 1'b0;
        end else if (!bus.hold) begin
            write_q  <= '0;
            constA_q <= 1'b0;
            if (bus.in_valid && state_q == S_OP) begin
                if (wordIllegal) begin
                    illegal_q <= 1'b1;
                end
                if (wordConst) begin
                    pendWord_q    <= word[34:0];
                    pendIllegal_q <= wordIllegal;
                    state_q       <= S_CONST;
                end
            end
            if (issueNow_d) begin
                op_q       <= issueWord_d[34:32];
                form_q     <= issueWord_d[31];
                vec_q      <= issueWord_d[30:29];
                write_q    <= issueIllegal_d ? 2'b00 : issueWord_d[28:27];
                a_q        <= issueWord_d[23:20];
                b_q        <= issueWord_d[19:16];
                c_q        <= issueWord_d[15:12];
                d_q        <= issueWord_d[11:8];
                y1_q       <= issueWord_d[7:4];
                y2_q       <= issueWord_d[3:0];
                constA_q   <= issueConst_d;
                constant_q <= issueConst_d ? word[31:0] : 32'd0;
                zeroReg_q  <= {issueWord_d[11:8] == 4'd0,
                               issueWord_d[15:12] == 4'd0,
                               issueWord_d[19:16] == 4'd0,
                               (issueWord_d[23:20] == 4'd0) & ~issueConst_d};
                if (!issueIllegal_d) begin
                    issuedCount_q <= issuedCount_q + CNT_W'(1);
                end
                state_q <= S_OP;
            end
        end
    end

    assign bus.op           = op_q;
    assign bus.form         = form_q;
    assign bus.vec          = vec_q;
    assign bus.A            = a_q;
    assign bus.B            = b_q;
    assign bus.C            = c_q;
    assign bus.D            = d_q;
    assign bus.zero_reg     = zeroReg_q;
    assign bus.Y1           = y1_q;
    assign bus.Y2           = y2_q;
    assign bus.write        = write_q;
    assign bus.const_a      = constA_q;
    assign bus.constant     = constant_q;
    assign bus.issued_count = issuedCount_q;
    assign bus.illegal      = illegal_q;

endmodule

// File: tb/tb_instr_decode.sv
// ---------------------------------------------------------------------------
// tb_instr_decode
// Directed bench for instr_decode built with CNT_W=4 so the counter wrap is
// reachable quickly. Inputs change 1 ns after the rising edge; outputs are
// sampled there too, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_instr_decode;

    localparam int INSTR_W = 36;
    localparam int CNT_W   = 4;

    logic clk;
    logic rst_n;
    int   checkCount;
    int   errorCount;

    instr_decode_if #(.INSTR_W(INSTR_W), .CNT_W(CNT_W)) bus ();

    instr_decode #(.INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Build an op word from its fields.
    function automatic logic [35:0] mkOp(
        input logic       c,
        input logic [2:0] op,
        input logic       form,
        input logic [1:0] vec,
        input logic [1:0] wr,
        input logic [2:0] res,
        input logic [3:0] a, b, cc, d, y1, y2
    );
        return {c, op, form, vec, wr, res, a, b, cc, d, y1, y2};
    endfunction

    // Drive one cycle of inputs, then step past the rising edge.
    task automatic applyStimulus(input logic valid, input logic [35:0] w,
                                 input logic hld);
        bus.in_valid = valid;
        bus.in_word  = w;
        bus.hold     = hld;
        @(posedge clk);
        #1;
    endtask

    // Single comparison point: count it, report it if it differs.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag,
                     observed, expected);
        end
    endtask

    // Directed scenario sequence.
    initial begin
        checkCount   = 0;
        errorCount   = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_word  = '0;
        bus.hold     = 1'b0;

        // Reset state.
        applyStimulus(1'b0, 36'd0, 1'b0);
        applyStimulus(1'b0, 36'd0, 1'b0);
        checkOutput("rst_write",   64'(bus.write), 64'd0);
        checkOutput("rst_consta",  64'(bus.const_a), 64'd0);
        checkOutput("rst_const",   64'(bus.constant), 64'd0);
        checkOutput("rst_zero",    64'(bus.zero_reg), 64'd0);
        checkOutput("rst_count",   64'(bus.issued_count), 64'd0);
        checkOutput("rst_illegal", 64'(bus.illegal), 64'd0);
        checkOutput("rst_ready",   64'(bus.in_ready), 64'd1);
        rst_n = 1'b1;

        // Const load: op word then constant 5.
        applyStimulus(1'b1, mkOp(1'b1, 3'd0, 1'b0, 2'd0, 2'b01, 3'd0,
                                 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd0), 1'b0);
        checkOutput("cl_bubble_write", 64'(bus.write), 64'd0);
        checkOutput("cl_bubble_consta", 64'(bus.const_a), 64'd0);
        applyStimulus(1'b1, 36'd5, 1'b0);
        checkOutput("cl_write",  64'(bus.write), 64'b01);
        checkOutput("cl_y1",     64'(bus.Y1), 64'd1);
        checkOutput("cl_consta", 64'(bus.const_a), 64'd1);
        checkOutput("cl_const",  64'(bus.constant), 64'd5);
        checkOutput("cl_zero",   64'(bus.zero_reg), 64'b0000);
        checkOutput("cl_count",  64'(bus.issued_count), 64'd1);

        // Back-to-back plain instructions.
        applyStimulus(1'b1, mkOp(1'b0, 3'd0, 1'b0, 2'd0, 2'b01, 3'd0,
                                 4'd1, 4'd0, 4'd2, 4'd0, 4'd3, 4'd0), 1'b0);
        checkOutput("bb1_zero",   64'(bus.zero_reg), 64'b1010);
        checkOutput("bb1_write",  64'(bus.write), 64'b01);
        checkOutput("bb1_consta", 64'(bus.const_a), 64'd0);
        checkOutput("bb1_const",  64'(bus.constant), 64'd0);
        checkOutput("bb1_y1",     64'(bus.Y1), 64'd3);
        applyStimulus(1'b1, mkOp(1'b0, 3'b100, 1'b1, 2'd0, 2'b10, 3'd0,
                                 4'd3, 4'd1, 4'd2, 4'd0, 4'd0, 4'd3), 1'b0);
        checkOutput("bb2_zero",  64'(bus.zero_reg), 64'b1000);
        checkOutput("bb2_write", 64'(bus.write), 64'b10);
        checkOutput("bb2_op",    64'(bus.op), 64'b100);
        checkOutput("bb2_form",  64'(bus.form), 64'd1);
        checkOutput("bb2_y2",    64'(bus.Y2), 64'd3);
        checkOutput("bb2_count", 64'(bus.issued_count), 64'd3);

        // Hold for three cycles with a new word waiting.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, mkOp(1'b0, 3'b010, 1'b0, 2'b11, 2'b01, 3'd0,
                                     4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9), 1'b1);
            checkOutput("hold_ready", 64'(bus.in_ready), 64'd0);
            checkOutput("hold_write", 64'(bus.write), 64'b10);
            checkOutput("hold_op",    64'(bus.op), 64'b100);
            checkOutput("hold_count", 64'(bus.issued_count), 64'd3);
        end
        applyStimulus(1'b1, mkOp(1'b0, 3'b010, 1'b0, 2'b11, 2'b01, 3'd0,
                                 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9), 1'b0);
        checkOutput("rel_op",    64'(bus.op), 64'b010);
        checkOutput("rel_vec",   64'(bus.vec), 64'b11);
        checkOutput("rel_write", 64'(bus.write), 64'b01);
        checkOutput("rel_y1",    64'(bus.Y1), 64'd8);
        checkOutput("rel_zero",  64'(bus.zero_reg), 64'b0000);
        checkOutput("rel_count", 64'(bus.issued_count), 64'd4);
        applyStimulus(1'b0, 36'd0, 1'b0);
        checkOutput("idle_write", 64'(bus.write), 64'd0);
        checkOutput("idle_op",    64'(bus.op), 64'b010);
        checkOutput("idle_count", 64'(bus.issued_count), 64'd4);

        // Illegal op word, then a legal one.
        applyStimulus(1'b1, mkOp(1'b0, 3'b001, 1'b0, 2'd0, 2'b11, 3'b010,
                                 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2), 1'b0);
        checkOutput("ill_write",   64'(bus.write), 64'd0);
        checkOutput("ill_flag",    64'(bus.illegal), 64'd1);
        checkOutput("ill_count",   64'(bus.issued_count), 64'd4);
        checkOutput("ill_op",      64'(bus.op), 64'b001);
        checkOutput("ill_zero",    64'(bus.zero_reg), 64'b1111);
        applyStimulus(1'b1, mkOp(1'b0, 3'b011, 1'b0, 2'd0, 2'b01, 3'd0,
                                 4'd1, 4'd1, 4'd1, 4'd1, 4'd5, 4'd0), 1'b0);
        checkOutput("legal_write", 64'(bus.write), 64'b01);
        checkOutput("legal_count", 64'(bus.issued_count), 64'd5);
        checkOutput("legal_flag",  64'(bus.illegal), 64'd1);

        // Illegal const-flagged word: constant consumed, write suppressed.
        applyStimulus(1'b1, mkOp(1'b1, 3'd0, 1'b0, 2'd0, 2'b01, 3'b001,
                                 4'd2, 4'd2, 4'd2, 4'd2, 4'd6, 4'd0), 1'b0);
        checkOutput("illc_bubble", 64'(bus.write), 64'd0);
        applyStimulus(1'b1, 36'hF_0000_0007, 1'b0);
        checkOutput("illc_write",  64'(bus.write), 64'd0);
        checkOutput("illc_consta", 64'(bus.const_a), 64'd1);
        checkOutput("illc_const",  64'(bus.constant), 64'd7);
        checkOutput("illc_count",  64'(bus.issued_count), 64'd5);

        // Reset while waiting for a constant word; a word offered during
        // reset must be dropped.
        applyStimulus(1'b1, mkOp(1'b1, 3'd0, 1'b0, 2'd0, 2'b01, 3'd0,
                                 4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd0), 1'b0);
        rst_n = 1'b0;
        applyStimulus(1'b1, mkOp(1'b0, 3'b111, 1'b0, 2'd0, 2'b11, 3'd0,
                                 4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2), 1'b0);
        checkOutput("rc_write",   64'(bus.write), 64'd0);
        checkOutput("rc_op",      64'(bus.op), 64'd0);
        checkOutput("rc_count",   64'(bus.issued_count), 64'd0);
        checkOutput("rc_illegal", 64'(bus.illegal), 64'd0);
        checkOutput("rc_ready",   64'(bus.in_ready), 64'd1);
        rst_n = 1'b1;
        applyStimulus(1'b1, mkOp(1'b0, 3'b101, 1'b0, 2'd0, 2'b10, 3'd0,
                                 4'd1, 4'd0, 4'd1, 4'd1, 4'd0, 4'd4), 1'b0);
        checkOutput("rc_next_consta", 64'(bus.const_a), 64'd0);
        checkOutput("rc_next_write",  64'(bus.write), 64'b10);
        checkOutput("rc_next_op",     64'(bus.op), 64'b101);
        checkOutput("rc_next_zero",   64'(bus.zero_reg), 64'b0010);
        checkOutput("rc_next_count",  64'(bus.issued_count), 64'd1);

        // Counter wrap: 14 legal NOPs reach 15, one more wraps to 0.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b1, 36'd0, 1'b0);
        end
        checkOutput("wrap_top", 64'(bus.issued_count), 64'd15);
        applyStimulus(1'b1, 36'd0, 1'b0);
        checkOutput("wrap_zero", 64'(bus.issued_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/instr_decode.md
Name: instr_decode

Overview:
- Decode/issue stage directly upstream of `datapath`.
- Accepts instruction words from fetch over a valid/ready handshake.
- Assembles two-word constant-load instructions.
- Drives every `datapath` control input from registers: op, form, vec, A–D, zero_reg, Y1/Y2, write, const_a, constant.
- Inserts bubbles (write=00) whenever no instruction issues. Supports a downstream hold and reports illegal encodings.

Parameters:
- INSTR_W, 36, fetch word width. Fixed format below; other values unsupported.
- CNT_W, 16, width of the issued-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- in_valid  in  1  fetch word present.
- in_ready  out  1  decoder accepts the word this cycle.
- in_word  in  36  instruction or constant word.
- hold  in  1  downstream stall; freezes decoder.
- op  out  3  ALU operation.
- form  out  1  operand form select.
- vec  out  2  vector mode.
- A, B, C, D  out  4 each  source register indices.
- zero_reg  out  4  per-operand zero mask. Bit0=A, bit1=B, bit2=C, bit3=D; 1 = operand forced to zero.
- Y1, Y2  out  4 each  destination register indices.
- write  out  2  write enables; bit0 writes Y1, bit1 writes Y2.
- const_a  out  1  replace operand A with constant.
- constant  out  32  immediate value.
- issued_count  out  CNT_W  legal instructions issued.
- illegal  out  1  sticky illegal-encoding flag.

Behaviour:
- Op-word format:
  - [35] const flag
  - [34:32] op
  - [31] form
  - [30:29] vec
  - [28:27] write
  - [26:24] reserved; must be 0
  - [23:20] A, [19:16] B, [15:12] C, [11:8] D
  - [7:4] Y1, [3:0] Y2
- Constant word: bits [31:0] are the constant; bits [35:32] are ignored.
- Handshake:
  - in_ready = ~hold (combinational). A transfer occurs on a rising edge with in_valid & in_ready.
  - in_word must be stable while in_valid=1 and in_ready=0.
- FSM:
  - S_OP (reset state): expects an op word.
  - S_CONST: expects a constant word.
- S_OP, transfer, const flag=0:
  - Next cycle the outputs carry the decoded fields, with const_a=0 and constant=0.
- S_OP, transfer, const flag=1:
  - Latch the fields into a pending register and go to S_CONST.
  - Next cycle is a bubble.
- S_CONST, transfer:
  - Next cycle issues the pending fields with const_a=1 and constant=in_word[31:0].
  - Return to S_OP.
- No transfer while hold=0 (S_OP or S_CONST): next cycle is a bubble.
  - write=00 and const_a=0.
  - All other outputs keep their last values.
- Latency: word accepted at edge N → outputs valid after edge N (exactly one cycle) → datapath writes at edge N+1.
  - A const instruction issues one cycle after its constant word is accepted.
  - Back-to-back instructions issue one per cycle; no hazard interlock is needed because the outputs are registered.
- zero_reg on issue:
  - bit0 = (A==0) & ~const_a
  - bit1 = (B==0), bit2 = (C==0), bit3 = (D==0)
  - Register 0 reads as zero.
- hold=1: FSM, pending register, all outputs, issued_count and illegal are frozen; in_ready=0.
  - The instruction currently on the outputs is held, including its write enables.
- Illegal op word (reserved bits ≠ 0):
  - Issued with write forced to 00.
  - illegal set, and stays set until reset.
  - issued_count not incremented.
  - If the const flag is set, the following constant word is still consumed and discarded; the issue carries write=00.
- issued_count:
  - +1 on each legal issue, including a const issue on its issue cycle.
  - Wraps 2^CNT_W−1 → 0.
- Reset (rst_n=0 at edge), including mid-S_CONST:
  - State → S_OP; pending contents discarded.
  - All outputs → 0 (write=00, const_a=0, constant=0, zero_reg=0000); issued_count=0; illegal=0.
  - in_ready = ~hold during reset; words transferred while rst_n=0 are dropped.

Test Plan:
- Reset, then op word {const=1, write=01, A=0, B=C=D=1, Y1=1} followed by constant word 5.
  - One bubble cycle, then write=01, Y1=1, const_a=1, constant=5, zero_reg=0000.
  - Datapath r1=5; issued_count=1.
- Back-to-back non-const words {write=01, A=1, C=2, B=0, D=0, Y1=3} then {op=100, form=1, write=10, A=3, B=1, C=2, D=0, Y2=3}, in_valid held high.
  - Consecutive issue cycles: zero_reg=1010 then 1000.
  - write=01 then 10, const_a=0.
- Assert hold for 3 cycles while an instruction is on the outputs.
  - in_ready=0; outputs, issued_count and FSM unchanged.
  - Resumes correctly on release with no lost or duplicated word.
- Op word with reserved=3'b010 and write=11.
  - Issues with write=00; illegal=1 stays set; issued_count unchanged.
  - The next legal word issues normally.
- Reset asserted in S_CONST, between the op and constant words.
  - All outputs zero; the next word is decoded as an op word and no const instruction issues.
- Preload issued_count near wrap by issuing 2^CNT_W−1 legal NOPs (CNT_W=4 build): next legal issue → issued_count=0.
